// File: rtl/sd_iniciador.sv
// sd_iniciador: initiator side of the xs/fin start-done handshake.
// Issues a batch of start strobes to an SD instance, one run at a time.
// Each run completes when fin rises. A gap with fin low separates runs.
// A watchdog ends the batch in ERROR if a run never finishes.
module sd_iniciador #(
    parameter int CNT_W       = 8,
    parameter int XS_HOLD     = 1,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_ops,
    input  logic             fin,
    output logic             xs,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] ops_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]      HOLD_L  = 5'(XS_HOLD);
    localparam logic [4:0]      GAP_L   = 5'(GAP_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic [3:0]       hold_q, hold_d;
    logic [3:0]       gap_q, gap_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             xs_q, xs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    // Marks that DONE was just entered, so done pulses exactly once.
    logic             enter_done_q, enter_done_d;

    logic             hold_last;
    logic             gap_last;
    logic [CNT_W-1:0] ops_inc;

    // GAP_CYC == 0 makes gap_last true at once, so the first fin=0 cycle starts.
    assign hold_last = ({1'b0, hold_q} + 5'd1) >= HOLD_L;
    assign gap_last  = ({1'b0, gap_q} + 5'd1) >= GAP_L;
    assign ops_inc   = ops_q + CNT_W'(1);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        ops_d        = ops_q;
        hold_d       = hold_q;
        gap_d        = gap_q;
        wd_d         = wd_q;
        enter_done_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            hold_d  = 4'd0;
            gap_d   = 4'd0;
            wd_d    = '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (go) begin
                        n_d    = n_ops;
                        ops_d  = '0;
                        hold_d = 4'd0;
                        gap_d  = 4'd0;
                        wd_d   = '0;
                        if (n_ops == '0) begin
                            state_d      = DONE;
                            enter_done_d = 1'b1;
                        end else if (!fin) begin
                            state_d = START;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
                START: begin
                    if (hold_last) begin
                        hold_d  = 4'd0;
                        wd_d    = '0;
                        state_d = WAIT;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                WAIT: begin
                    if (fin) begin
                        ops_d = ops_inc;
                        wd_d  = '0;
                        if (ops_inc == n_q) begin
                            state_d      = DONE;
                            enter_done_d = 1'b1;
                        end else begin
                            gap_d   = 4'd0;
                            state_d = GAP;
                        end
                    end else if (wd_q == WD_LAST) begin
                        wd_d    = '0;
                        state_d = ERROR;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                GAP: begin
                    if (fin) begin
                        gap_d = 4'd0;
                    end else if (gap_last) begin
                        gap_d   = 4'd0;
                        hold_d  = 4'd0;
                        state_d = START;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        xs_d   = (state_d == START);
        busy_d = !abort && ((state_d == START) || (state_d == WAIT) ||
                            (state_d == GAP) || enter_done_d);
        done_d = !abort && (state_q == DONE) && enter_done_q;
        err_d  = (state_d == ERROR);
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            ops_q        <= '0;
            hold_q       <= 4'd0;
            gap_q        <= 4'd0;
            wd_q         <= '0;
            xs_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            enter_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            ops_q        <= ops_d;
            hold_q       <= hold_d;
            gap_q        <= gap_d;
            wd_q         <= wd_d;
            xs_q         <= xs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            enter_done_q <= enter_done_d;
        end
    end

    assign xs          = xs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign ops_count   = ops_q;

endmodule

// File: tb/tb_sd_iniciador.sv
// Directed self-checking bench for sd_iniciador (TIMEOUT_CYC reduced to 16).
module tb_sd_iniciador;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             go;
    logic             abort;
    logic [CNT_W-1:0] n_ops;
    logic             fin;
    logic             xs;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] ops_count;

    int tests = 0;
    int fails = 0;

    sd_iniciador #(
        .CNT_W(CNT_W), .XS_HOLD(1), .GAP_CYC(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .n_ops(n_ops),
        .fin(fin), .xs(xs), .busy(busy), .done(done),
        .timeout_err(timeout_err), .ops_count(ops_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until xs is seen high or the budget runs out; n = ticks taken.
    task automatic wait_xs(input int budget, output int n);
        n = 0;
        while (xs !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq("wait_xs_seen", {31'd0, xs}, 32'd1);
    endtask

    task automatic start_batch(input logic [CNT_W-1:0] n);
        n_ops = n;
        go    = 1'b1;
        tick();
        go    = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; go = 1'b0; abort = 1'b0; n_ops = '0; fin = 1'b0;
        #12;
        check_eq("rst_xs", {31'd0, xs}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ops", {24'd0, ops_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Batch of 3, fin pulse 5 cycles after each xs.
        start_batch(8'd3);
        check_eq("b_xs_first", {31'd0, xs}, 32'd1);
        check_eq("b_busy", {31'd0, busy}, 32'd1);
        for (int r = 0; r < 3; r++) begin
            tick();
            check_eq("b_xs_width", {31'd0, xs}, 32'd0);
            for (int k = 0; k < 3; k++) tick();
            check_eq("b_busy_wait", {31'd0, busy}, 32'd1);
            fin = 1'b1;
            tick();
            fin = 1'b0;
            check_eq("b_ops", {24'd0, ops_count}, r + 1);
            if (r < 2) begin
                wait_xs(10, n);
                check_eq("b_gap", n, 32'd2);
            end else begin
                check_eq("b_done_early", {31'd0, done}, 32'd0);
                check_eq("b_busy_last", {31'd0, busy}, 32'd1);
                tick();
                check_eq("b_done", {31'd0, done}, 32'd1);
                check_eq("b_busy_fall", {31'd0, busy}, 32'd0);
                tick();
                check_eq("b_done_once", {31'd0, done}, 32'd0);
                check_eq("b_ops_hold", {24'd0, ops_count}, 32'd3);
            end
        end

        // n_ops = 0: no xs, done two cycles after go.
        start_batch(8'd0);
        check_eq("z_xs", {31'd0, xs}, 32'd0);
        check_eq("z_done_early", {31'd0, done}, 32'd0);
        check_eq("z_ops_clr", {24'd0, ops_count}, 32'd0);
        tick();
        check_eq("z_done", {31'd0, done}, 32'd1);
        check_eq("z_xs2", {31'd0, xs}, 32'd0);
        tick();
        check_eq("z_done_once", {31'd0, done}, 32'd0);

        // Watchdog: fin held low, ERROR after 16 WAIT cycles.
        start_batch(8'd2);
        check_eq("t_xs", {31'd0, xs}, 32'd1);
        tick();
        for (int k = 0; k < 15; k++) tick();
        check_eq("t_err_early", {31'd0, timeout_err}, 32'd0);
        check_eq("t_busy_early", {31'd0, busy}, 32'd1);
        tick();
        check_eq("t_err", {31'd0, timeout_err}, 32'd1);
        check_eq("t_busy", {31'd0, busy}, 32'd0);
        check_eq("t_ops", {24'd0, ops_count}, 32'd0);
        tick();
        check_eq("t_err_sticky", {31'd0, timeout_err}, 32'd1);
        start_batch(8'd1);
        check_eq("t_restart_err", {31'd0, timeout_err}, 32'd0);
        check_eq("t_restart_xs", {31'd0, xs}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("a_xs", {31'd0, xs}, 32'd0);
        check_eq("a_busy", {31'd0, busy}, 32'd0);

        // Stale fin at go: xs only after 2 cycles of fin low.
        fin = 1'b1;
        start_batch(8'd1);
        check_eq("s_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check_eq("s_no_xs", {31'd0, xs}, 32'd0);
            tick();
        end
        fin = 1'b0;
        wait_xs(10, n);
        check_eq("s_gap", n, 32'd2);
        tick();
        fin = 1'b1;
        tick();
        fin = 1'b0;
        tick();
        check_eq("s_done", {31'd0, done}, 32'd1);
        check_eq("s_ops", {24'd0, ops_count}, 32'd1);

        // Abort during the second run's WAIT.
        start_batch(8'd4);
        tick();
        tick();
        fin = 1'b1;
        tick();
        fin = 1'b0;
        wait_xs(10, n);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_busy", {31'd0, busy}, 32'd0);
        check_eq("ab_ops", {24'd0, ops_count}, 32'd1);
        check_eq("ab_done", {31'd0, done}, 32'd0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        tick();
        check_eq("ab_idle_ops", {24'd0, ops_count}, 32'd1);
        check_eq("ab_no_done", {31'd0, done}, 32'd0);
        go = 1'b1; abort = 1'b1; n_ops = 8'd2;
        tick();
        go = 1'b0; abort = 1'b0;
        check_eq("ga_busy", {31'd0, busy}, 32'd0);
        check_eq("ga_xs", {31'd0, xs}, 32'd0);
        tick();
        check_eq("ga_xs2", {31'd0, xs}, 32'd0);
        check_eq("ga_ops", {24'd0, ops_count}, 32'd1);

        // Asynchronous reset in the middle of WAIT.
        start_batch(8'd2);
        tick();
        fin = 1'b1;
        tick();
        fin = 1'b0;
        wait_xs(10, n);
        tick();
        check_eq("r_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #2;
        check_eq("r_xs", {31'd0, xs}, 32'd0);
        check_eq("r_busy", {31'd0, busy}, 32'd0);
        check_eq("r_done", {31'd0, done}, 32'd0);
        check_eq("r_err", {31'd0, timeout_err}, 32'd0);
        check_eq("r_ops", {24'd0, ops_count}, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check_eq("r_idle_xs", {31'd0, xs}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sd_iniciador.md
Name: sd_iniciador

Overview:
Initiator side of the xs/fin start–done handshake used by the SD digital system. On a host request it issues N start pulses (xs) to an SD instance, one at a time. Each run completes when fin rises. A gap and a fin-low check separate runs. A per-run watchdog flags an SD that never finishes. It sits between host control logic and the SD (UC+UD) top, in the same clock domain.

Parameters:
CNT_W, 8, width of run-count request and completed-run counter
XS_HOLD, 1, cycles xs stays high per run (1..15)
GAP_CYC, 2, minimum idle cycles between fin falling and the next xs (0..15)
TIMEOUT_CYC, 1024, max cycles waited for fin after xs deasserts (>=2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
go  input  1  host request; sampled only in IDLE, DONE or ERROR
abort  input  1  synchronous cancel; returns FSM to IDLE
n_ops  input  CNT_W  number of SD runs; latched when go is accepted
fin  input  1  SD completion flag, synchronous to clk
xs  output  1  start strobe to SD
busy  output  1  high from go acceptance until DONE or ERROR is entered
done  output  1  one-cycle pulse when all runs complete
timeout_err  output  1  sticky; high while in ERROR
ops_count  output  CNT_W  runs completed in current or last batch

Behaviour:
- Reset (reset=0, async): state=IDLE; xs=0, busy=0, done=0, timeout_err=0, ops_count=0; all internal counters 0.
- States: IDLE, START, WAIT, GAP, DONE, ERROR. All outputs are registered.
- IDLE/DONE/ERROR with go=1 and abort=0:
  - Latch n_ops.
  - Clear ops_count and timeout_err.
  - busy=1 next cycle.
  - If latched n_ops=0: go to DONE; done pulses 1 cycle later and xs never asserts.
  - Otherwise, if fin=0: go to START.
  - Otherwise (fin=1, stale): go to GAP, which waits for fin=0 first.
- START: xs=1 for exactly XS_HOLD cycles, then WAIT. The first xs high cycle is the cycle after go is sampled.
- WAIT: xs=0; watchdog counts from 0.
  - fin=1: ops_count+1, watchdog cleared.
    - If ops_count+1 equals latched n_ops: go to DONE.
    - Otherwise: go to GAP.
  - Watchdog reaches TIMEOUT_CYC with fin still 0: go to ERROR.
  - fin already high during START is ignored. Completion is recognised only in WAIT.
- GAP: waits until fin=0, then counts GAP_CYC consecutive cycles with fin=0, then START. If fin rises again during the count, the count restarts. With GAP_CYC=0, START follows the first fin=0 cycle.
- DONE: done=1 for the single cycle after entry, then 0. busy=0. ops_count holds. Stays in DONE until go.
- ERROR: timeout_err=1 (sticky), busy=0, xs=0, ops_count holds the runs that completed. Stays until go (restart) or abort (to IDLE; timeout_err cleared).
- abort=1 in any state: next state IDLE, xs=0 next cycle, busy=0, done=0. ops_count holds.
- abort and go high together: abort wins.
- go while busy: ignored; n_ops is not re-latched.
- ops_count saturates only at latched n_ops; it never wraps, since it cannot exceed n_ops.
- Watchdog width: clog2(TIMEOUT_CYC+1). Gap and hold counters: 4 bits.

Test Plan:
- Reset mid-WAIT: assert reset=0 asynchronously -> xs, busy, done, timeout_err and ops_count all 0 in the same cycle, without waiting for a clock edge; state=IDLE.
- Batch of 3, fin pulses 5 cycles after each xs -> exactly 3 single-cycle xs pulses, each at least GAP_CYC=2 cycles after the previous fin fell; ops_count goes 1,2,3; done pulses once; busy falls with done.
- n_ops=0 with go -> no xs; done pulses 2 cycles after go; ops_count=0.
- TIMEOUT_CYC=16, fin held 0 -> ERROR after 16 WAIT cycles; timeout_err=1, busy=0, ops_count=0. A later go -> timeout_err clears and a new xs is issued.
- fin stuck high at go with n_ops=1 -> no xs until fin drops. xs follows 2 cycles of fin=0; then fin pulse -> done.
- abort during the second run's WAIT with n_ops=4 -> IDLE next cycle, ops_count=1, no done pulse. A simultaneous go+abort in IDLE -> stays in IDLE.
